// File: rtl/nibble_sub16.sv
// -----------------------------------------------------------------------------
// nibble_sub16
// Multi-cycle subtractor: diff = a - b - bin (mod 2^W), computed one 4-bit
// slice per clock, least-significant nibble first. Each slice is an adder in
// complement form (A_i + ~B_i + carry), so carry=1 means "no borrow".
//
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   start  : operation request, accepted only while ready=1
//   a, b   : minuend / subtrahend, sampled on the accepting edge only
//   bin    : borrow in, sampled on the accepting edge only
//   ready  : 1 while idle
//   busy   : 1 while nibbles are being processed
//   done   : one-cycle pulse when diff and the flags are updated
//   diff   : registered result
//   bout   : borrow out (1 = unsigned a < b + bin)
//   zero   : diff == 0
//   neg    : diff MSB
//   ovf    : signed overflow of the subtraction
// -----------------------------------------------------------------------------
module nibble_sub16 #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 bin,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] diff,
    output logic                 bout,
    output logic                 zero,
    output logic                 neg,
    output logic                 ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed overflow of a - b: operands of different sign and the result
    // sign differs from the minuend.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    state_t         state_r;
    state_t         state_s;

    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   partial_r;
    logic           carry_r;
    logic [IW-1:0]  idx_r;

    logic [3:0]     nib_a_s;
    logic [3:0]     nib_b_s;
    logic [4:0]     sum_s;
    logic           ready_s;
    logic           busy_s;

    logic [W-1:0]   diff_r;
    logic           bout_r;
    logic           zero_r;
    logic           neg_r;
    logic           ovf_r;
    logic           done_r;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == IDX_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Handshake status decoded from the state register only
    always_comb begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        case (state_r)
            ST_IDLE: ready_s = 1'b1;
            ST_RUN:  busy_s  = 1'b1;
            ST_DONE: begin
                ready_s = 1'b0;
                busy_s  = 1'b0;
            end
            default: begin
                ready_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // One nibble slice: A_i + ~B_i + carry, 5-bit result
    always_comb begin
        nib_a_s = a_r[{idx_r, 2'b00} +: 4];
        nib_b_s = b_r[{idx_r, 2'b00} +: 4];
        sum_s   = {1'b0, nib_a_s} + {1'b0, ~nib_b_s} + {4'b0000, carry_r};
    end

    // Operand latch and nibble-serial carry chain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r       <= {W{1'b0}};
            b_r       <= {W{1'b0}};
            partial_r <= {W{1'b0}};
            carry_r   <= 1'b0;
            idx_r     <= {IW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r       <= a;
                        b_r       <= b;
                        partial_r <= {W{1'b0}};
                        carry_r   <= ~bin;   // borrow in becomes inverted carry in
                        idx_r     <= {IW{1'b0}};
                    end
                end
                ST_RUN: begin
                    partial_r[{idx_r, 2'b00} +: 4] <= sum_s[3:0];
                    carry_r                        <= sum_s[4];
                    idx_r                          <= idx_r + IW'(1);
                end
                default: begin
                    carry_r <= carry_r;
                end
            endcase
        end
    end

    // Result and flag registers; only the DONE cycle updates them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_r <= {W{1'b0}};
            bout_r <= 1'b0;
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == ST_DONE);
            if (state_r == ST_DONE) begin
                diff_r <= partial_r;
                bout_r <= ~carry_r;
                zero_r <= (partial_r == {W{1'b0}});
                neg_r  <= partial_r[W-1];
                ovf_r  <= sub_ovf(a_r[W-1], b_r[W-1], partial_r[W-1]);
            end
        end
    end

    assign ready = ready_s;
    assign busy  = busy_s;
    assign done  = done_r;
    assign diff  = diff_r;
    assign bout  = bout_r;
    assign zero  = zero_r;
    assign neg   = neg_r;
    assign ovf   = ovf_r;

endmodule
